// File: rtl/count_monitor_pkg.sv
// Shared types and default sizes for the count_monitor checker.
package count_monitor_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WRAP_W = 8;

    // Event kinds reported on the event port.
    typedef enum logic [1:0] {
        EVT_NONE     = 2'b00,
        EVT_TOP      = 2'b01,
        EVT_BOTTOM   = 2'b10,
        EVT_STEP_ERR = 2'b11
    } evt_code_t;

    // INIT captures a reference sample; TRACK checks every step against it.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/count_monitor_evt_slot.sv
// One-entry valid/ready event holding register. A new event loads when the
// slot is empty or drains on the same edge; otherwise it is dropped and the
// sticky overflow flag is raised while the held entry stays untouched.
module evt_slot
    import count_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  evt_code_t        in_code,
    input  logic [WIDTH-1:0] in_data,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [1:0]       evt_code,
    output logic [WIDTH-1:0] evt_data,
    output logic             ovf
);

    logic xfer;
    logic load;
    logic drop;

    assign xfer = evt_valid && evt_ready;
    assign load = in_valid && (!evt_valid || xfer);
    assign drop = in_valid && evt_valid && !xfer;

    // Slot contents: load on room, drain on transfer, flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_code  <= 2'b00;
            evt_data  <= '0;
            ovf       <= 1'b0;
        end else if (clear) begin
            evt_valid <= 1'b0;
            evt_code  <= 2'b00;
            evt_data  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (load) begin
                evt_valid <= 1'b1;
                evt_code  <= in_code;
                evt_data  <= in_data;
            end else if (xfer) begin
                evt_valid <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Step checker for an up/down counter: verifies each sample is a legal +/-1
// move from the previous one, reports TOP/BOTTOM/STEP_ERR events, counts
// legal wraps (saturating) and keeps sticky error status.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count,
    input  logic              mode,
    input  logic              clear,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_code,
    output logic [WIDTH-1:0]  evt_data,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic              ovf
);

    localparam logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  prev;
    logic              mode_q;
    logic [WIDTH-1:0]  expected;
    logic              step_err;
    logic              top_hit;
    logic              bottom_hit;
    logic              wrap_hit;
    logic              new_valid;
    evt_code_t         new_code;
    logic [WRAP_W-1:0] wrap_q;
    logic              err_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next state and step classification; nothing is flagged in INIT or
    // on a clearing edge, so those edges raise no event and count no wrap.
    always_comb begin
        next_state = ST_TRACK;
        expected   = mode_q ? (prev - 1'b1) : (prev + 1'b1);
        step_err   = 1'b0;
        top_hit    = 1'b0;
        bottom_hit = 1'b0;
        wrap_hit   = 1'b0;
        new_code   = EVT_NONE;
        if (clear) begin
            next_state = ST_INIT;
        end else if (state == ST_TRACK) begin
            step_err   = (count != expected);
            top_hit    = !step_err && !mode_q && (count == MAX_VAL);
            bottom_hit = !step_err &&  mode_q && (count == '0);
            wrap_hit   = !step_err && ((!mode_q && (count == '0)) ||
                                       ( mode_q && (count == MAX_VAL)));
        end
        if (step_err) begin
            new_code = EVT_STEP_ERR;
        end else if (top_hit) begin
            new_code = EVT_TOP;
        end else if (bottom_hit) begin
            new_code = EVT_BOTTOM;
        end
    end

    assign new_valid = (new_code != EVT_NONE);

    // Reference sample and its direction; resyncs to the observed value on
    // every edge, including after a step error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= '0;
            mode_q <= 1'b0;
        end else begin
            prev   <= count;
            mode_q <= mode;
        end
    end

    // Saturating wrap counter and sticky step-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= '0;
            err_q  <= 1'b0;
        end else if (clear) begin
            wrap_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wrap_hit && (wrap_q != WRAP_MAX)) begin
                wrap_q <= wrap_q + 1'b1;
            end
            if (step_err) begin
                err_q <= 1'b1;
            end
        end
    end

    evt_slot #(
        .WIDTH (WIDTH)
    ) u_evt_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (new_valid),
        .in_code   (new_code),
        .in_data   (count),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_data  (evt_data),
        .ovf       (ovf)
    );

    assign wrap_cnt = wrap_q;
    assign err      = err_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_count_monitor;
    import count_monitor_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] count;
    logic       mode;
    logic       clear;
    logic       evt_ready;
    logic       evt_valid, evt_valid2;
    logic [1:0] evt_code, evt_code2;
    logic [3:0] evt_data, evt_data2;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_cnt2;
    logic       err, err2;
    logic       ovf, ovf2;

    count_monitor #(.WIDTH(4), .WRAP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .count(count), .mode(mode), .clear(clear),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_data(evt_data), .wrap_cnt(wrap_cnt), .err(err), .ovf(ovf)
    );

    count_monitor #(.WIDTH(4), .WRAP_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .count(count), .mode(mode), .clear(clear),
        .evt_valid(evt_valid2), .evt_ready(evt_ready), .evt_code(evt_code2),
        .evt_data(evt_data2), .wrap_cnt(wrap_cnt2), .err(err2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Pending events live in a queue of capacity one, encoded code*16+data.
    bit m_init;
    int m_prev;
    bit m_mode;
    int evq[$];
    int m_wraps;
    bit m_err;
    bit m_ovf;

    task automatic model_reset();
        m_init  = 1'b1;
        m_prev  = 0;
        m_mode  = 1'b0;
        evq.delete();
        m_wraps = 0;
        m_err   = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input int c, input bit md, input bit rdy, input bit clr);
        int ev;
        int want;
        if (clr) begin
            model_reset();
            return;
        end
        ev = -1;
        if (rdy && evq.size() > 0) void'(evq.pop_front());
        if (!m_init) begin
            want = (m_prev + (m_mode ? 15 : 1)) % 16;
            if (c != want) begin
                ev    = 3 * 16 + c;
                m_err = 1'b1;
            end else begin
                if (!m_mode && c == 15) ev = 1 * 16 + c;
                if (m_mode && c == 0)   ev = 2 * 16 + c;
                if ((!m_mode && c == 0) || (m_mode && c == 15)) m_wraps++;
            end
        end
        if (ev >= 0) begin
            if (evq.size() == 0) evq.push_back(ev);
            else m_ovf = 1'b1;
        end
        m_init = 1'b0;
        m_prev = c;
        m_mode = md;
    endtask

    task automatic model_compare();
        check("rand_valid", evt_valid, evq.size() > 0);
        check("rand_valid_w2", evt_valid2, evq.size() > 0);
        if (evq.size() > 0) begin
            check("rand_code", evt_code, evq[0] / 16);
            check("rand_data", evt_data, evq[0] % 16);
            check("rand_code_w2", evt_code2, evq[0] / 16);
            check("rand_data_w2", evt_data2, evq[0] % 16);
        end
        check("rand_wrap", wrap_cnt, (m_wraps > 255) ? 255 : m_wraps);
        check("rand_wrap_w2", wrap_cnt2, (m_wraps > 3) ? 3 : m_wraps);
        check("rand_err", err, m_err);
        check("rand_err_w2", err2, m_err);
        check("rand_ovf", ovf, m_ovf);
        check("rand_ovf_w2", ovf2, m_ovf);
    endtask

    // Apply one sample across a rising edge, then advance the model.
    task automatic step(input logic [3:0] c, input logic md, input logic rdy, input logic clr);
        count     = c;
        mode      = md;
        evt_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
        model_edge(int'(c), md, rdy, clr);
    endtask

    // Asynchronous reset pulse placed away from the clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", evt_valid, 1'b0);
        check("arst_code", evt_code, 2'b00);
        check("arst_data", evt_data, 4'h0);
        check("arst_wrap", wrap_cnt, 8'h00);
        check("arst_err", err, 1'b0);
        check("arst_ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] c;
        logic       md, rdy, clr;
        logic       ev;
        logic [1:0] code;
        logic [3:0] data;
        logic [7:0] wrap;
        logic       er, ov;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] c, input logic md, input logic rdy, input logic clr,
                       input logic ev, input logic [1:0] code, input logic [3:0] data,
                       input logic [7:0] wrap, input logic er, input logic ov);
        vec_t v;
        v.c = c; v.md = md; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.code = code; v.data = data; v.wrap = wrap; v.er = er; v.ov = ov;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t v;
        bit   gmode;
        int   gcount;
        bit   rdy;
        bit   clr;

        rst_n = 1'b0; clear = 1'b0; mode = 1'b0; evt_ready = 1'b0; count = 4'h0;
        model_reset();
        #3;
        check("reset_valid", evt_valid, 1'b0);
        check("reset_code", evt_code, 2'b00);
        check("reset_data", evt_data, 4'h0);
        check("reset_wrap", wrap_cnt, 8'h00);
        check("reset_err", err, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Up 0..F..0: TOP on F, wrap on 0.
        for (int i = 0; i < 15; i++) add(4'(i), 0, 1, 0, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'hF, 0, 1, 0, 1, 2'd1, 4'hF, 8'd0, 0, 0);
        add(4'h0, 0, 1, 0, 0, 2'd0, 4'd0, 8'd1, 0, 0);
        // 1,2,3,7,8,9: STEP_ERR on 7, resync on 8, err sticky.
        add(4'h1, 0, 1, 0, 0, 2'd0, 4'd0, 8'd1, 0, 0);
        add(4'h2, 0, 1, 0, 0, 2'd0, 4'd0, 8'd1, 0, 0);
        add(4'h3, 0, 1, 0, 0, 2'd0, 4'd0, 8'd1, 0, 0);
        add(4'h7, 0, 1, 0, 1, 2'd3, 4'h7, 8'd1, 1, 0);
        add(4'h8, 0, 1, 0, 0, 2'd0, 4'd0, 8'd1, 1, 0);
        add(4'h9, 0, 1, 0, 0, 2'd0, 4'd0, 8'd1, 1, 0);
        // Clear, then up to 5 turning down: BOTTOM on 0, wrap on F.
        add(4'h2, 0, 1, 1, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'h3, 0, 1, 0, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'h4, 0, 1, 0, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'h5, 1, 1, 0, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'h4, 1, 1, 0, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'h3, 1, 1, 0, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'h2, 1, 1, 0, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'h1, 1, 1, 0, 0, 2'd0, 4'd0, 8'd0, 0, 0);
        add(4'h0, 1, 1, 0, 1, 2'd2, 4'h0, 8'd0, 0, 0);
        add(4'hF, 1, 1, 0, 0, 2'd0, 4'd0, 8'd1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            step(v.c, v.md, v.rdy, v.clr);
            check("tbl_valid", evt_valid, v.ev);
            if (v.ev) begin
                check("tbl_code", evt_code, v.code);
                check("tbl_data", evt_data, v.data);
            end
            check("tbl_wrap", wrap_cnt, v.wrap);
            check("tbl_err", err, v.er);
            check("tbl_ovf", ovf, v.ov);
        end

        // Back-pressure: TOP held, BOTTOM dropped, then transfer.
        step(4'h0, 0, 0, 1);
        step(4'hE, 0, 0, 0);
        step(4'hF, 1, 0, 0);
        check("bp_top_valid", evt_valid, 1'b1);
        check("bp_top_code", evt_code, 2'd1);
        for (int c = 14; c >= 1; c--) begin
            step(4'(c), 1, 0, 0);
            check("bp_hold_data", evt_data, 4'hF);
        end
        step(4'h0, 1, 0, 0);
        check("bp_drop_valid", evt_valid, 1'b1);
        check("bp_drop_code", evt_code, 2'd1);
        check("bp_drop_data", evt_data, 4'hF);
        check("bp_drop_ovf", ovf, 1'b1);
        step(4'hF, 1, 1, 0);
        check("bp_xfer_valid", evt_valid, 1'b0);
        check("bp_xfer_ovf", ovf, 1'b1);
        check("bp_xfer_wrap", wrap_cnt, 8'd1);

        // Transfer and new event on the same edge: load without overflow.
        step(4'h0, 0, 0, 1);
        check("clr_ovf", ovf, 1'b0);
        step(4'h1, 1, 0, 0);
        step(4'h0, 1, 0, 0);
        check("same_bottom_code", evt_code, 2'd2);
        step(4'h5, 1, 1, 0);
        check("same_valid", evt_valid, 1'b1);
        check("same_code", evt_code, 2'd3);
        check("same_data", evt_data, 4'h5);
        check("same_ovf", ovf, 1'b0);
        step(4'h4, 1, 1, 0);
        check("same_drain", evt_valid, 1'b0);

        // Asynchronous reset mid-count; tracking restarts from the next sample.
        step(4'h0, 0, 0, 1);
        step(4'h7, 0, 0, 0);
        step(4'h8, 0, 0, 0);
        step(4'h9, 0, 0, 0);
        step(4'hB, 0, 0, 0);
        check("pre_arst_err", err, 1'b1);
        async_reset();
        step(4'h3, 0, 0, 0);
        check("post_arst_err", err, 1'b0);
        check("post_arst_valid", evt_valid, 1'b0);
        step(4'h4, 0, 0, 0);
        check("post_arst_legal", err, 1'b0);
        step(4'h6, 0, 0, 0);
        check("post_arst_err_back", err, 1'b1);
        check("post_arst_data", evt_data, 4'h6);

        // Synchronous clear behaves the same way.
        step(4'h3, 0, 0, 1);
        check("clr_valid", evt_valid, 1'b0);
        check("clr_err", err, 1'b0);
        step(4'h3, 0, 0, 0);
        check("post_clr_err", err, 1'b0);
        step(4'h4, 0, 0, 0);
        check("post_clr_legal", err, 1'b0);
        step(4'h9, 0, 0, 0);
        check("post_clr_err_back", err, 1'b1);

        // Five full up wraps: narrow counter saturates at 3.
        step(4'h0, 0, 1, 1);
        step(4'h0, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            for (int c = 1; c < 16; c++) step(4'(c), 0, 1, 0);
            step(4'h0, 0, 1, 0);
            check("wrap8", wrap_cnt, 8'(k));
            check("wrap2", wrap_cnt2, (k > 3) ? 2'd3 : 2'(k));
        end

        // Randomized run against the model.
        gmode  = 1'b0;
        gcount = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(19) == 0) gcount = $urandom_range(15);
            else gcount = (gcount + (gmode ? 15 : 1)) % 16;
            if ($urandom_range(9) == 0) gmode = ~gmode;
            rdy = 1'($urandom_range(1));
            clr = ($urandom_range(39) == 0);
            step(4'(gcount), gmode, rdy, clr);
            model_compare();
            if ($urandom_range(299) == 0) begin
                async_reset();
                model_compare();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
